// File: rtl/phys_reg_release_queue_if.sv
// ---------------------------------------------------------------------------
// phys_reg_release_queue_if
//   Groups the retire-side and free-list-side signals of the physical
//   register release queue.
//
//   Handshake semantics: a retire transfer happens on a rising CLK edge when
//   retire_valid and retire_ready are both high. retire_ready depends only on
//   registered state, never on retire_valid. On the free-list side the free
//   list accepts unconditionally whenever enqueue_valid is high, so there is
//   no ready. The producer must not raise enqueue_valid while free_list_full
//   is high.
//
//   Modports:
//     master : commit stage plus free list, i.e. the testbench or the
//              surrounding core
//     slave  : the release queue itself
// ---------------------------------------------------------------------------
interface phys_reg_release_queue_if #(
  parameter int TAG_WIDTH = 6
);
  logic                 retire_valid;
  logic [TAG_WIDTH-1:0] retire_phys_reg_tag;
  logic                 retire_ready;
  logic                 enqueue_valid;
  logic [TAG_WIDTH-1:0] enqueue_phys_reg_tag;
  logic                 free_list_full;

  modport master (
    output retire_valid, retire_phys_reg_tag, free_list_full,
    input  retire_ready, enqueue_valid, enqueue_phys_reg_tag
  );

  modport slave (
    input  retire_valid, retire_phys_reg_tag, free_list_full,
    output retire_ready, enqueue_valid, enqueue_phys_reg_tag
  );
endinterface

// File: rtl/phys_reg_release_queue.sv
// ---------------------------------------------------------------------------
// phys_reg_release_queue
//   Buffers stale physical register tags coming from the commit stage and
//   hands them to the free list one per cycle, in acceptance order. Tag 0 is
//   never released: an accepted tag of 0 is silently dropped.
//
//   Ports:
//     CLK        : clock; all state updates on the rising edge
//     nRST       : asynchronous active-low reset
//     bus        : slave side of phys_reg_release_queue_if
//                  (retire_valid, retire_phys_reg_tag, retire_ready,
//                   enqueue_valid, enqueue_phys_reg_tag, free_list_full)
//     occupancy  : number of buffered tags (tail - head)
//     DUT_error  : registered protocol-violation flag. It is set for a
//                  double free (free_list_full while the queue is non-empty)
//                  or for a retire offered while the queue is full.
//
//   Optional feature macro: PHYS_REG_RELEASE_BYPASS_EN
//     When defined, a nonzero tag accepted while the queue is empty and the
//     free list is not full goes straight to enqueue_* in the same cycle and
//     is not written into the array.
// ---------------------------------------------------------------------------
module phys_reg_release_queue #(
  parameter int RELEASE_QUEUE_DEPTH     = 4,
  parameter int LOG_RELEASE_QUEUE_DEPTH = 2,
  parameter int TAG_WIDTH               = 6
) (
  input  logic                             CLK,
  input  logic                             nRST,
  phys_reg_release_queue_if.slave          bus,
  output logic [LOG_RELEASE_QUEUE_DEPTH:0] occupancy,
  output logic                             DUT_error
);

  localparam int PW = LOG_RELEASE_QUEUE_DEPTH + 1;
  localparam int IW = LOG_RELEASE_QUEUE_DEPTH;

  typedef logic [TAG_WIDTH-1:0] phys_reg_tag_t;

  // The pointers carry one extra msb so that full and empty can be told apart
  // when the indices are equal.
  logic [PW-1:0] head, tail, head_next, tail_next;
  logic          full_q, empty_q, full_next, empty_next;
  phys_reg_tag_t mem [RELEASE_QUEUE_DEPTH];

  logic accept, accept_nonzero, pop, bypass, write_en;

  always_comb begin
    accept         = bus.retire_valid & ~full_q;
    accept_nonzero = accept & (bus.retire_phys_reg_tag != '0);
    pop            = ~empty_q & ~bus.free_list_full;
`ifdef PHYS_REG_RELEASE_BYPASS_EN
    bypass         = empty_q & ~bus.free_list_full & accept_nonzero;
`else
    bypass         = 1'b0;
`endif
    write_en       = accept_nonzero & ~bypass;
    head_next      = head + {{IW{1'b0}}, pop};
    tail_next      = tail + {{IW{1'b0}}, write_en};
    empty_next     = (head_next == tail_next);
    full_next      = (head_next[IW-1:0] == tail_next[IW-1:0]) &
                     (head_next[IW] != tail_next[IW]);
  end

  assign bus.retire_ready         = ~full_q;
  assign bus.enqueue_valid        = pop | bypass;
  assign bus.enqueue_phys_reg_tag = bypass ? bus.retire_phys_reg_tag
                                           : mem[head[IW-1:0]];
  assign occupancy                = tail - head;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head      <= '0;
      tail      <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      DUT_error <= 1'b0;
    end else begin
      head      <= head_next;
      tail      <= tail_next;
      empty_q   <= empty_next;
      full_q    <= full_next;
      DUT_error <= (bus.free_list_full & ~empty_q) |
                   (bus.retire_valid & full_q);
    end
  end

  // The array has no reset. Its contents are meaningless while the queue
  // is empty.
  always_ff @(posedge CLK) begin
    if (write_en) begin
      mem[tail[IW-1:0]] <= bus.retire_phys_reg_tag;
    end
  end

endmodule

// File: tb/tb_phys_reg_release_queue.sv
module tb_phys_reg_release_queue;

  localparam int DEPTH = 4;
  localparam int LOGD  = 2;
  localparam int TW    = 6;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic nRST;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  phys_reg_release_queue_if #(.TAG_WIDTH(TW)) bus ();
  logic [LOGD:0] occupancy;
  logic          DUT_error;

  phys_reg_release_queue #(
    .RELEASE_QUEUE_DEPTH    (DEPTH),
    .LOG_RELEASE_QUEUE_DEPTH(LOGD),
    .TAG_WIDTH              (TW)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus),
    .occupancy(occupancy),
    .DUT_error(DUT_error)
  );

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [TW-1:0] exp_q[$];   // accepted, not yet released tags in order
  logic err_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge and hold for one cycle.
  task automatic cyc(input logic v, input logic [TW-1:0] t, input logic f);
    bus.retire_valid        = v;
    bus.retire_phys_reg_tag = t;
    bus.free_list_full      = f;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- monitor / reference model ----------------
  // The model treats the queue as an ordered list of pending tags. Each
  // cycle it works out acceptance and release from that list and the
  // current inputs. It compares the outputs and then advances the list.
  int   n;
  logic m_ready, m_acc, m_nz, m_byp, m_valid;
  logic [TW-1:0] m_tag;

  always @(negedge CLK) begin
    if (!nRST) begin
      check("rst_retire_ready", 32'(bus.retire_ready), 32'd1);
      check("rst_enqueue_valid", 32'(bus.enqueue_valid), 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_DUT_error", 32'(DUT_error), 32'd0);
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      n       = exp_q.size();
      m_ready = (n < DEPTH);
      m_acc   = bus.retire_valid & m_ready;
      m_nz    = m_acc & (bus.retire_phys_reg_tag != '0);
      m_byp   = 1'b0;
`ifdef PHYS_REG_RELEASE_BYPASS_EN
      m_byp   = (n == 0) && !bus.free_list_full && m_nz;
`endif
      m_valid = ((n > 0) && !bus.free_list_full) || m_byp;

      check("retire_ready", 32'(bus.retire_ready), 32'(m_ready));
      check("enqueue_valid", 32'(bus.enqueue_valid), 32'(m_valid));
      check("occupancy", 32'(occupancy), 32'(n));
      check("DUT_error", 32'(DUT_error), 32'(err_exp));

      err_exp = (bus.free_list_full && (n > 0)) ||
                (bus.retire_valid && !m_ready);

      if (m_nz) exp_q.push_back(bus.retire_phys_reg_tag);

      if (bus.enqueue_valid) begin
        if (exp_q.size() == 0) begin
          check("release_unexpected", 32'(bus.enqueue_phys_reg_tag), 32'hFFFF_FFFF);
        end else begin
          m_tag = exp_q.pop_front();
          check("release_tag", 32'(bus.enqueue_phys_reg_tag), 32'(m_tag));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    nRST = 1'b0;
    bus.retire_valid        = 1'b0;
    bus.retire_phys_reg_tag = '0;
    bus.free_list_full      = 1'b0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;

    // Three back-to-back tags with free flow.
    cyc(1, 6'd33, 0);
    cyc(1, 6'd34, 0);
    cyc(1, 6'd35, 0);
    repeat (3) cyc(0, 0, 0);

    // Tag 0 is dropped. Only 40 comes out.
    cyc(1, 6'd0, 0);
    cyc(1, 6'd40, 0);
    repeat (3) cyc(0, 0, 0);

    // Fill while the free list is full, try one more, then drain.
    cyc(1, 6'd11, 1);
    cyc(1, 6'd12, 1);
    cyc(1, 6'd13, 1);
    cyc(1, 6'd14, 1);
    cyc(1, 6'd15, 1);      // offered while full: not accepted, flagged
    cyc(0, 0, 1);
    repeat (6) cyc(0, 0, 0);

    // Hold two entries, then push and pop together for 10 cycles.
    cyc(1, 6'd21, 1);
    cyc(1, 6'd22, 1);
    for (int i = 0; i < 10; i++) cyc(1, 6'(50 + i), 0);
    repeat (4) cyc(0, 0, 0);

    // Reset in the middle of a drain with three entries still buffered.
    cyc(1, 6'd41, 1);
    cyc(1, 6'd42, 1);
    cyc(1, 6'd43, 1);
    cyc(1, 6'd44, 1);
    cyc(0, 0, 0);          // one released, three left
    nRST = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    nRST = 1'b1;
    repeat (4) cyc(0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0,
          ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
          $urandom_range(0, 3) == 0);
    end
    repeat (8) cyc(0, 0, 0);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
